// File: rtl/speicher_zugriff.sv
// speicher_zugriff -- memory access sequencer between the control FSM and a
// simple handshake memory bus.
//
// Serves one request at a time, with a fixed priority of store, then load,
// then fetch. Each transaction holds a bus strobe until MemBereit arrives or
// the wait budget (TIMEOUT cycles) runs out. It then spends one DONE cycle
// pulsing the completion flag for that request type.
//
// State table:
//   state      | meaning
//   IDLE       | waiting for a request; latches address/data on accept
//   FETCH_BUSY | MemLesen held, waiting for the instruction word
//   LOAD_BUSY  | MemLesen held, waiting for the data word
//   STORE_BUSY | MemSchreiben held, waiting for the write acknowledge
//   DONE       | one-cycle completion pulse; request inputs ignored
//
// Ports:
//   Clock, Reset (sync, active-low)
//   LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal : request levels
//   PC, DatenAdresse, StoreDaten                        : request operands
//   Befehl, GeladeneDaten                               : captured read results
//   BefehlGeladen, DatenGeladen, DatenGespeichert       : completion pulses
//   Zeitueberschreitung                                 : sticky timeout flag
//   MemAdresse, MemSchreibDaten, MemLesen, MemSchreiben : bus request side
//   MemBereit, MemLeseDaten                             : bus response side
module speicher_zugriff #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LoadBefehlSignal,
    input  logic        LoadDatenSignal,
    input  logic        StoreDatenSignal,
    input  logic [31:0] PC,
    input  logic [31:0] DatenAdresse,
    input  logic [31:0] StoreDaten,
    output logic [31:0] Befehl,
    output logic [31:0] GeladeneDaten,
    output logic        BefehlGeladen,
    output logic        DatenGeladen,
    output logic        DatenGespeichert,
    output logic        Zeitueberschreitung,
    output logic [31:0] MemAdresse,
    output logic [31:0] MemSchreibDaten,
    output logic        MemLesen,
    output logic        MemSchreiben,
    input  logic        MemBereit,
    input  logic [31:0] MemLeseDaten
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_BUSY,
        LOAD_BUSY,
        STORE_BUSY,
        DONE
    } stateT;

    typedef enum logic [1:0] {
        OP_FETCH,
        OP_LOAD,
        OP_STORE
    } opT;

    // A wait cycle whose counter already equals TIMEOUT-1 is the TIMEOUT-th
    // cycle without an acknowledge, so the transaction ends on that edge.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    stateT      state;
    stateT      nextState;
    opT         op;
    logic [7:0] waitCnt;
    logic       busy;
    logic       expired;

    assign busy    = (state == FETCH_BUSY) || (state == LOAD_BUSY) || (state == STORE_BUSY);
    assign expired = busy && !MemBereit && (waitCnt == TimeoutLast);

    // Strobes and pulses decode directly from the state register, so both
    // bus strobes can never be high together and reset clears them at once.
    assign MemLesen         = (state == FETCH_BUSY) || (state == LOAD_BUSY);
    assign MemSchreiben     = (state == STORE_BUSY);
    assign BefehlGeladen    = (state == DONE) && (op == OP_FETCH);
    assign DatenGeladen     = (state == DONE) && (op == OP_LOAD);
    assign DatenGespeichert = (state == DONE) && (op == OP_STORE);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (StoreDatenSignal) begin
                    nextState = STORE_BUSY;
                end else if (LoadDatenSignal) begin
                    nextState = LOAD_BUSY;
                end else if (LoadBefehlSignal) begin
                    nextState = FETCH_BUSY;
                end
            end
            FETCH_BUSY, LOAD_BUSY, STORE_BUSY: begin
                if (MemBereit || expired) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            op                  <= OP_FETCH;
            waitCnt             <= 8'd0;
            Befehl              <= 32'h0;
            GeladeneDaten       <= 32'h0;
            Zeitueberschreitung <= 1'b0;
            MemAdresse          <= 32'h0;
            MemSchreibDaten     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= 8'd0;
                    if (StoreDatenSignal) begin
                        op              <= OP_STORE;
                        MemAdresse      <= DatenAdresse;
                        MemSchreibDaten <= StoreDaten;
                    end else if (LoadDatenSignal) begin
                        op         <= OP_LOAD;
                        MemAdresse <= DatenAdresse;
                    end else if (LoadBefehlSignal) begin
                        op         <= OP_FETCH;
                        MemAdresse <= PC;
                    end
                end
                FETCH_BUSY, LOAD_BUSY, STORE_BUSY: begin
                    if (MemBereit) begin
                        if (state == FETCH_BUSY) begin
                            Befehl <= MemLeseDaten;
                        end else if (state == LOAD_BUSY) begin
                            GeladeneDaten <= MemLeseDaten;
                        end
                    end else if (expired) begin
                        // A timed-out read leaves a defined zero rather than stale data.
                        Zeitueberschreitung <= 1'b1;
                        if (state == FETCH_BUSY) begin
                            Befehl <= 32'h0;
                        end else if (state == LOAD_BUSY) begin
                            GeladeneDaten <= 32'h0;
                        end
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speicher_zugriff.sv
module tb_speicher_zugriff;

    logic        Clock;
    logic        Reset;
    logic        LoadBefehlSignal;
    logic        LoadDatenSignal;
    logic        StoreDatenSignal;
    logic [31:0] PC;
    logic [31:0] DatenAdresse;
    logic [31:0] StoreDaten;
    logic [31:0] Befehl;
    logic [31:0] GeladeneDaten;
    logic        BefehlGeladen;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic        Zeitueberschreitung;
    logic [31:0] MemAdresse;
    logic [31:0] MemSchreibDaten;
    logic        MemLesen;
    logic        MemSchreiben;
    logic        MemBereit;
    logic [31:0] MemLeseDaten;

    int errors = 0;
    int checks = 0;

    speicher_zugriff #(.TIMEOUT(4)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .LoadBefehlSignal(LoadBefehlSignal),
        .LoadDatenSignal(LoadDatenSignal),
        .StoreDatenSignal(StoreDatenSignal),
        .PC(PC),
        .DatenAdresse(DatenAdresse),
        .StoreDaten(StoreDaten),
        .Befehl(Befehl),
        .GeladeneDaten(GeladeneDaten),
        .BefehlGeladen(BefehlGeladen),
        .DatenGeladen(DatenGeladen),
        .DatenGespeichert(DatenGespeichert),
        .Zeitueberschreitung(Zeitueberschreitung),
        .MemAdresse(MemAdresse),
        .MemSchreibDaten(MemSchreibDaten),
        .MemLesen(MemLesen),
        .MemSchreiben(MemSchreiben),
        .MemBereit(MemBereit),
        .MemLeseDaten(MemLeseDaten)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge Clock);
    endtask

    task automatic test_reset();
        logic [197:0] allOut;
        allOut = {Befehl, GeladeneDaten, MemAdresse, MemSchreibDaten, MemLesen, MemSchreiben,
                  BefehlGeladen, DatenGeladen, DatenGespeichert, Zeitueberschreitung};
        checks++;
        if (allOut !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%0h exp=0", allOut);
        end
        Reset = 1'b1;
        cyc();
        checks++;
        if ({MemLesen, MemSchreiben, BefehlGeladen} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=000", {MemLesen, MemSchreiben, BefehlGeladen});
        end
    endtask

    task automatic test_fetch();
        PC = 32'h100;
        LoadBefehlSignal = 1'b1;
        cyc();
        checks++;
        if ({MemLesen, MemSchreiben, BefehlGeladen, MemAdresse} !== {3'b100, 32'h100}) begin
            errors++;
            $display("FAIL fetch_busy got=%b/%0h exp=100/100", {MemLesen, MemSchreiben, BefehlGeladen}, MemAdresse);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'hDEADBEEF;
        LoadBefehlSignal = 1'b0;
        cyc();
        checks++;
        if ({MemLesen, BefehlGeladen, Befehl} !== {2'b01, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL fetch_done got=%b/%0h exp=01/deadbeef", {MemLesen, BefehlGeladen}, Befehl);
        end
        MemBereit = 1'b0;
        cyc();
        checks++;
        if ({MemLesen, BefehlGeladen} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after got=%b exp=00", {MemLesen, BefehlGeladen});
        end
    endtask

    task automatic test_load();
        DatenAdresse = 32'h1000;
        LoadDatenSignal = 1'b1;
        cyc();
        checks++;
        if ({MemLesen, MemSchreiben, MemAdresse} !== {2'b10, 32'h1000}) begin
            errors++;
            $display("FAIL load_busy got=%b/%0h exp=10/1000", {MemLesen, MemSchreiben}, MemAdresse);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'hCAFEF00D;
        LoadDatenSignal = 1'b0;
        cyc();
        checks++;
        if ({DatenGeladen, BefehlGeladen, GeladeneDaten, Befehl} !== {2'b10, 32'hCAFEF00D, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_done got=%b/%0h/%0h exp=10/cafef00d/deadbeef",
                     {DatenGeladen, BefehlGeladen}, GeladeneDaten, Befehl);
        end
        MemBereit = 1'b0;
        cyc();
    endtask

    task automatic test_store();
        DatenAdresse = 32'h2000;
        StoreDaten = 32'h12345678;
        StoreDatenSignal = 1'b1;
        cyc();
        StoreDatenSignal = 1'b0;
        DatenAdresse = 32'hFFFF;
        StoreDaten = 32'hAAAA5555;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({MemSchreiben, MemLesen, DatenGespeichert, MemAdresse, MemSchreibDaten} !==
                {3'b100, 32'h2000, 32'h12345678}) begin
                errors++;
                $display("FAIL store_busy%0d got=%b/%0h/%0h exp=100/2000/12345678", i,
                         {MemSchreiben, MemLesen, DatenGespeichert}, MemAdresse, MemSchreibDaten);
            end
            if (i == 3) MemBereit = 1'b1;
            cyc();
        end
        checks++;
        if ({MemSchreiben, DatenGespeichert, DatenGeladen, GeladeneDaten} !== {3'b010, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL store_done got=%b/%0h exp=010/cafef00d",
                     {MemSchreiben, DatenGespeichert, DatenGeladen}, GeladeneDaten);
        end
        MemBereit = 1'b0;
        cyc();
        checks++;
        if ({MemSchreiben, DatenGespeichert} !== 2'b00) begin
            errors++;
            $display("FAIL store_after got=%b exp=00", {MemSchreiben, DatenGespeichert});
        end
    endtask

    task automatic test_priority();
        PC = 32'h300;
        DatenAdresse = 32'h400;
        StoreDaten = 32'h0BADF00D;
        LoadBefehlSignal = 1'b1;
        LoadDatenSignal = 1'b1;
        StoreDatenSignal = 1'b1;
        cyc();
        checks++;
        if ({MemSchreiben, MemLesen, MemAdresse, MemSchreibDaten} !== {2'b10, 32'h400, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL prio_store got=%b/%0h/%0h exp=10/400/badf00d",
                     {MemSchreiben, MemLesen}, MemAdresse, MemSchreibDaten);
        end
        MemBereit = 1'b1;
        cyc();
        checks++;
        if ({DatenGespeichert, DatenGeladen, BefehlGeladen} !== 3'b100) begin
            errors++;
            $display("FAIL prio_store_pulse got=%b exp=100", {DatenGespeichert, DatenGeladen, BefehlGeladen});
        end
        MemBereit = 1'b0;
        StoreDatenSignal = 1'b0;
        cyc();
        checks++;
        if ({MemLesen, MemSchreiben, DatenGespeichert} !== 3'b000) begin
            errors++;
            $display("FAIL prio_idle got=%b exp=000", {MemLesen, MemSchreiben, DatenGespeichert});
        end
        cyc();
        checks++;
        if ({MemLesen, MemAdresse} !== {1'b1, 32'h400}) begin
            errors++;
            $display("FAIL prio_load got=%b/%0h exp=1/400", MemLesen, MemAdresse);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'h11112222;
        cyc();
        checks++;
        if ({DatenGeladen, BefehlGeladen, GeladeneDaten, Befehl} !== {2'b10, 32'h11112222, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL prio_load_done got=%b/%0h/%0h exp=10/11112222/deadbeef",
                     {DatenGeladen, BefehlGeladen}, GeladeneDaten, Befehl);
        end
        MemBereit = 1'b0;
        LoadDatenSignal = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({MemLesen, MemAdresse} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL prio_fetch got=%b/%0h exp=1/300", MemLesen, MemAdresse);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'h33334444;
        cyc();
        checks++;
        if ({BefehlGeladen, Befehl, GeladeneDaten} !== {1'b1, 32'h33334444, 32'h11112222}) begin
            errors++;
            $display("FAIL prio_fetch_done got=%b/%0h/%0h exp=1/33334444/11112222",
                     BefehlGeladen, Befehl, GeladeneDaten);
        end
        MemBereit = 1'b0;
        LoadBefehlSignal = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        checks++;
        if (Zeitueberschreitung !== 1'b0) begin
            errors++;
            $display("FAIL to_pre got=%b exp=0", Zeitueberschreitung);
        end
        DatenAdresse = 32'h500;
        LoadDatenSignal = 1'b1;
        cyc();
        LoadDatenSignal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({MemLesen, Zeitueberschreitung, DatenGeladen} !== 3'b100) begin
                errors++;
                $display("FAIL to_wait%0d got=%b exp=100", i, {MemLesen, Zeitueberschreitung, DatenGeladen});
            end
            cyc();
        end
        checks++;
        if ({MemLesen, DatenGeladen, Zeitueberschreitung, GeladeneDaten} !== {3'b011, 32'h0}) begin
            errors++;
            $display("FAIL to_done got=%b/%0h exp=011/0",
                     {MemLesen, DatenGeladen, Zeitueberschreitung}, GeladeneDaten);
        end
        cyc();
        PC = 32'h600;
        LoadBefehlSignal = 1'b1;
        cyc();
        MemBereit = 1'b1;
        MemLeseDaten = 32'h55;
        LoadBefehlSignal = 1'b0;
        cyc();
        checks++;
        if ({BefehlGeladen, Zeitueberschreitung, Befehl} !== {2'b11, 32'h55}) begin
            errors++;
            $display("FAIL to_sticky got=%b/%0h exp=11/55", {BefehlGeladen, Zeitueberschreitung}, Befehl);
        end
        MemBereit = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [197:0] allOut;
        DatenAdresse = 32'h900;
        LoadDatenSignal = 1'b1;
        cyc();
        checks++;
        if (MemLesen !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy got=%b exp=1", MemLesen);
        end
        Reset = 1'b0;
        MemBereit = 1'b1;
        MemLeseDaten = 32'h99999999;
        cyc();
        allOut = {Befehl, GeladeneDaten, MemAdresse, MemSchreibDaten, MemLesen, MemSchreiben,
                  BefehlGeladen, DatenGeladen, DatenGespeichert, Zeitueberschreitung};
        checks++;
        if (allOut !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear got=%0h exp=0", allOut);
        end
        Reset = 1'b1;
        MemBereit = 1'b0;
        LoadDatenSignal = 1'b0;
        cyc();
        checks++;
        if ({MemLesen, DatenGeladen} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_nopulse got=%b exp=00", {MemLesen, DatenGeladen});
        end
        PC = 32'h700;
        LoadBefehlSignal = 1'b1;
        cyc();
        checks++;
        if ({MemLesen, MemAdresse} !== {1'b1, 32'h700}) begin
            errors++;
            $display("FAIL rst_mid_fetch got=%b/%0h exp=1/700", MemLesen, MemAdresse);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'h77;
        LoadBefehlSignal = 1'b0;
        cyc();
        checks++;
        if ({BefehlGeladen, Befehl, Zeitueberschreitung} !== {1'b1, 32'h77, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_done got=%b/%0h/%b exp=1/77/0", BefehlGeladen, Befehl, Zeitueberschreitung);
        end
        MemBereit = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        PC = 32'h800;
        LoadBefehlSignal = 1'b1;
        cyc();
        MemBereit = 1'b1;
        MemLeseDaten = 32'hA0A0A0A0;
        cyc();
        checks++;
        if ({BefehlGeladen, Befehl} !== {1'b1, 32'hA0A0A0A0}) begin
            errors++;
            $display("FAIL b2b_first got=%b/%0h exp=1/a0a0a0a0", BefehlGeladen, Befehl);
        end
        // Acknowledge with junk data during DONE and IDLE must be ignored.
        MemLeseDaten = 32'hBAD0BAD0;
        cyc();
        checks++;
        if ({BefehlGeladen, MemLesen, Befehl} !== {2'b00, 32'hA0A0A0A0}) begin
            errors++;
            $display("FAIL b2b_idle got=%b/%0h exp=00/a0a0a0a0", {BefehlGeladen, MemLesen}, Befehl);
        end
        MemBereit = 1'b0;
        cyc();
        checks++;
        if ({MemLesen, BefehlGeladen, Befehl} !== {2'b10, 32'hA0A0A0A0}) begin
            errors++;
            $display("FAIL b2b_second_busy got=%b/%0h exp=10/a0a0a0a0", {MemLesen, BefehlGeladen}, Befehl);
        end
        MemBereit = 1'b1;
        MemLeseDaten = 32'hB1B1B1B1;
        cyc();
        checks++;
        if ({BefehlGeladen, Befehl} !== {1'b1, 32'hB1B1B1B1}) begin
            errors++;
            $display("FAIL b2b_second got=%b/%0h exp=1/b1b1b1b1", BefehlGeladen, Befehl);
        end
        MemBereit = 1'b0;
        LoadBefehlSignal = 1'b0;
        cyc();
        checks++;
        if (BefehlGeladen !== 1'b0) begin
            errors++;
            $display("FAIL b2b_single_pulse got=%b exp=0", BefehlGeladen);
        end
        cyc();
        checks++;
        if (MemLesen !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_reissue got=%b exp=0", MemLesen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        LoadBefehlSignal = 1'b0;
        LoadDatenSignal = 1'b0;
        StoreDatenSignal = 1'b0;
        PC = 32'h0;
        DatenAdresse = 32'h0;
        StoreDaten = 32'h0;
        MemBereit = 1'b0;
        MemLeseDaten = 32'h0;
        cyc();
        cyc();
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
